wb_port_arbiter: RTL

- Owns the single register-file write port and shares it between two writers:
  - the main pipeline writeback stage, which has priority;
  - a buffered secondary requester (multi-cycle mul/div, late load returns) using a valid/ready handshake.
- Sits between WB and the register file; drives the register file's write_enabled/write_addr/write_data.
- Provides pending-write hazard flags to decode and a starvation-driven pipeline stall.

---
 rtl/wb_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//
// Purpose:
//   Owns the single register-file write port and shares it between the main
//   pipeline writeback stage (priority) and a buffered secondary requester
//   (multi-cycle mul/div, late load returns). Secondary writes are queued in a
//   small in-order FIFO. A starvation counter forces one FIFO drain, stalling
//   the pipeline for that cycle, when the head has waited MAX_WAIT cycles.
//   Decode gets hazard flags for registers that still have a queued write.
//
// Parameters:
//   DEPTH    - secondary FIFO entries (power of 2, >= 2)
//   MAX_WAIT - cycles a FIFO head may wait before a forced grant (>= 1)
//
// Ports:
//   clk, rst                        clock (rising edge), async active-low reset
//   pipe_we/pipe_addr/pipe_data     pipeline writeback request
//   pipe_stall                      pipeline must hold its WB this cycle
//   mc_valid/mc_ready               secondary request handshake
//   mc_addr/mc_data                 secondary destination and data
//   q_addr_1..3                     decode sources (1,2) and destination (3)
//   hazard_1..3                     q_addr_k matches a queued write
//   rf_we/rf_addr/rf_data           register file write port
//   fwd_hit_1/2, fwd_data_1/2       in-flight write forwarding (WB_BYPASS_EN)
//
// Configuration:
//   WB_BYPASS_EN - when defined, adds forwarding of the write in flight on the
//                  register-file port to the two decode source operands.
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_addr,
    input  logic [31:0] pipe_data,
    output logic        pipe_stall,
    input  logic        mc_valid,
    output logic        mc_ready,
    input  logic [4:0]  mc_addr,
    input  logic [31:0] mc_data,
    input  logic [4:0]  q_addr_1,
    input  logic [4:0]  q_addr_2,
    input  logic [4:0]  q_addr_3,
    output logic        hazard_1,
    output logic        hazard_2,
    output logic        hazard_3,
`ifdef WB_BYPASS_EN
    output logic        fwd_hit_1,
    output logic        fwd_hit_2,
    output logic [31:0] fwd_data_1,
    output logic [31:0] fwd_data_2,
`endif
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = AW + 1;
    localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_WAIT);

    typedef enum logic [1:0] {
        GNT_IDLE  = 2'd0,
        GNT_FORCE = 2'd1,
        GNT_PIPE  = 2'd2,
        GNT_DRAIN = 2'd3
    } gnt_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q,  count_d;
    logic [WW-1:0] wait_q,   wait_d;

    // Entry storage has no reset: validity comes only from pointers/count.
    // The head is read combinationally because the grant is decided in the
    // same cycle it is written to the register file.
    logic [4:0]  addr_mem [DEPTH];
    logic [31:0] data_mem [DEPTH];

    logic        fifo_empty;
    logic        fifo_full;
    logic [4:0]  head_addr;
    logic [31:0] head_data;
    logic        pipe_req;
    logic        accept;
    logic        push;
    logic        pop;
    gnt_t        gnt;

    // Wrap bit distinguishes full from empty when the low bits coincide.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                        (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign head_addr = addr_mem[rd_ptr_q[AW-1:0]];
    assign head_data = data_mem[rd_ptr_q[AW-1:0]];

    // A pipeline write to $0 is not a request at all.
    assign pipe_req = pipe_we && (pipe_addr != 5'd0);

    // Readiness depends only on the current fill level: a slot freed by a
    // pop this cycle is not reusable until the next cycle.
    assign mc_ready = rst && !fifo_full;
    assign accept   = mc_valid && mc_ready;
    // Writes to $0 are acknowledged and silently discarded.
    assign push     = accept && (mc_addr != 5'd0);

    // ------------------------------------------------------------------
    // Grant selection and write-port drive
    // ------------------------------------------------------------------
    always_comb begin
        gnt        = GNT_IDLE;
        rf_we      = 1'b0;
        rf_addr    = 5'd0;
        rf_data    = 32'd0;
        pipe_stall = 1'b0;
        pop        = 1'b0;

        if (!rst) begin
            gnt = GNT_IDLE;
        end else if ((wait_q == WAIT_LIMIT) && !fifo_empty) begin
            gnt = GNT_FORCE;
        end else if (pipe_req) begin
            gnt = GNT_PIPE;
        end else if (!fifo_empty) begin
            gnt = GNT_DRAIN;
        end

        case (gnt)
            GNT_FORCE: begin
                // The pipeline keeps its WB and re-presents it next cycle.
                rf_we      = 1'b1;
                rf_addr    = head_addr;
                rf_data    = head_data;
                pipe_stall = 1'b1;
                pop        = 1'b1;
            end
            GNT_PIPE: begin
                rf_we   = 1'b1;
                rf_addr = pipe_addr;
                rf_data = pipe_data;
            end
            GNT_DRAIN: begin
                rf_we   = 1'b1;
                rf_addr = head_addr;
                rf_data = head_data;
                pop     = 1'b1;
            end
            default: begin
                rf_we = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state: pointers, occupancy, starvation counter
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wait_d   = wait_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + PW'(1);
            2'b01:   count_d = count_q - PW'(1);
            default: count_d = count_q;
        endcase

        // The counter measures how long the current head has been blocked.
        // A pop hands over to a fresh head, so it restarts from zero; after
        // a forced grant the next force is therefore MAX_WAIT+1 cycles away.
        if (fifo_empty || pop) begin
            wait_d = '0;
        end else if (wait_q != WAIT_LIMIT) begin
            wait_d = wait_q + WW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wait_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wait_q   <= wait_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q[AW-1:0]] <= mc_addr;
            data_mem[wr_ptr_q[AW-1:0]] <= mc_data;
        end
    end

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    // An entry is live when its distance from the read pointer is below the
    // occupancy. The head being popped this cycle is already on the write
    // port, so it no longer counts as pending.
    logic [DEPTH-1:0] entry_live;
    logic [DEPTH-1:0] match_1;
    logic [DEPTH-1:0] match_2;
    logic [DEPTH-1:0] match_3;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [AW-1:0] offset;
        assign offset         = AW'(gi) - rd_ptr_q[AW-1:0];
        assign entry_live[gi] = ({1'b0, offset} < count_q) &&
                                !(pop && (offset == '0));
        assign match_1[gi]    = entry_live[gi] && (addr_mem[gi] == q_addr_1);
        assign match_2[gi]    = entry_live[gi] && (addr_mem[gi] == q_addr_2);
        assign match_3[gi]    = entry_live[gi] && (addr_mem[gi] == q_addr_3);
    end

    logic pend_1;
    logic pend_2;
    logic pend_3;

    assign pend_1 = rst && (q_addr_1 != 5'd0) && (|match_1);
    assign pend_2 = rst && (q_addr_2 != 5'd0) && (|match_2);
    assign pend_3 = rst && (q_addr_3 != 5'd0) && (|match_3);

`ifdef WB_BYPASS_EN
    // The register file returns pre-write data during its write cycle, so
    // the value on the write port is forwarded to the decode sources.
    assign fwd_hit_1  = rf_we && (rf_addr == q_addr_1) && (q_addr_1 != 5'd0);
    assign fwd_hit_2  = rf_we && (rf_addr == q_addr_2) && (q_addr_2 != 5'd0);
    assign fwd_data_1 = rf_data;
    assign fwd_data_2 = rf_data;

    // A forwarded hit clears the hazard only when no other queued entry
    // still targets the register. The popped head is already excluded from
    // pend_k, so any remaining match is such an "other" entry.
    assign hazard_1 = pend_1 && !(fwd_hit_1 && !(|match_1));
    assign hazard_2 = pend_2 && !(fwd_hit_2 && !(|match_2));
`else
    assign hazard_1 = pend_1;
    assign hazard_2 = pend_2;
`endif
    // Destination check guards WAW against queued writes; never forwarded.
    assign hazard_3 = pend_3;

endmodule
